// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: FSM states, queued prediction entry, instruction size.
// Queued targets are stored at MAX_ADDR_WIDTH bits; the top module narrows them to ADDR_WIDTH.
package branch_pkg;

  localparam int INSTR_BYTES    = 4;
  localparam int MAX_ADDR_WIDTH = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic                      taken;
    logic [MAX_ADDR_WIDTH-1:0] target;
    logic [1:0]                way;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-push, execute-resolve and predictor-training signals of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  i_pred_valid;
  logic                  i_pred_taken;
  logic [ADDR_WIDTH-1:0] i_pred_target;
  logic [1:0]            i_pred_way;
  logic                  o_pred_ready;
  logic                  i_exec_valid;
  logic                  i_exec_is_branch;
  logic                  i_exec_taken;
  logic [ADDR_WIDTH-1:0] i_exec_pc;
  logic [ADDR_WIDTH-1:0] i_exec_target;
  logic                  i_flush;
  logic                  o_mispredict;
  logic [ADDR_WIDTH-1:0] o_redirect_pc;
  logic                  o_bpu_update;
  logic                  o_bpu_taken;
  logic [ADDR_WIDTH-1:0] o_bpu_pc_exec;
  logic [ADDR_WIDTH-1:0] o_bpu_target_exec;
  logic [1:0]            o_bpu_way_write;
  logic                  o_underflow;
  logic [31:0]           o_branch_count;
  logic [31:0]           o_mispredict_count;

  modport slave (
    input  i_pred_valid, i_pred_taken, i_pred_target, i_pred_way,
    input  i_exec_valid, i_exec_is_branch, i_exec_taken, i_exec_pc, i_exec_target,
    input  i_flush,
    output o_pred_ready, o_mispredict, o_redirect_pc,
    output o_bpu_update, o_bpu_taken, o_bpu_pc_exec, o_bpu_target_exec, o_bpu_way_write,
    output o_underflow, o_branch_count, o_mispredict_count
  );

  modport master (
    output i_pred_valid, i_pred_taken, i_pred_target, i_pred_way,
    output i_exec_valid, i_exec_is_branch, i_exec_taken, i_exec_pc, i_exec_target,
    output i_flush,
    input  o_pred_ready, o_mispredict, o_redirect_pc,
    input  o_bpu_update, o_bpu_taken, o_bpu_pc_exec, o_bpu_target_exec, o_bpu_way_write,
    input  o_underflow, o_branch_count, o_mispredict_count
  );

endinterface

// File: rtl/branch_resolve_unit_pred_queue.sv
// Circular FIFO of fetch-time prediction entries; clear wins over push and pop.
// Callers guarantee push only when not full and pop only when not empty.
module pred_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  pred_entry_t            i_data,
  output pred_entry_t            o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pred_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage carries no reset; only the pointers and count decide what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against execute outcomes, issues redirects and BPU training.
// Optional macro BRANCH_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  branch_resolve_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  bru_state_e            r_state;
  logic                  r_mispredict;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;
  logic                  r_bpu_update;
  logic                  r_bpu_taken;
  logic [ADDR_WIDTH-1:0] r_bpu_pc_exec;
  logic [ADDR_WIDTH-1:0] r_bpu_target_exec;
  logic [1:0]            r_bpu_way_write;
  logic                  r_underflow;

  pred_entry_t           w_push_entry;
  pred_entry_t           w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_run;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underflow;
  logic                  w_clear;
  logic [ADDR_WIDTH-1:0] w_head_target;
  logic                  w_mis;
  logic [ADDR_WIDTH-1:0] w_redirect;

  assign w_run = (r_state == RUN);
  // Ready is gated by reset so that every output reads 0 while reset is held.
  assign w_ready     = i_arst & w_run & (w_count < CNT_W'(DEPTH));
  assign w_push      = bus.i_pred_valid & w_ready;
  assign w_pop       = w_run & bus.i_exec_valid & (w_count != '0);
  assign w_underflow = w_run & bus.i_exec_valid & (w_count == '0);

  assign w_push_entry = '{taken:  bus.i_pred_taken,
                          target: MAX_ADDR_WIDTH'(bus.i_pred_target),
                          way:    bus.i_pred_way};

  assign w_head_target = ADDR_WIDTH'(w_head.target);

  assign w_mis = w_pop &
                 (( bus.i_exec_is_branch & (w_head.taken != bus.i_exec_taken)) |
                  ( bus.i_exec_is_branch & bus.i_exec_taken & w_head.taken &
                    (w_head_target != bus.i_exec_target)) |
                  (!bus.i_exec_is_branch & w_head.taken));

  assign w_redirect = (bus.i_exec_taken & bus.i_exec_is_branch) ? bus.i_exec_target
                    : bus.i_exec_pc + ADDR_WIDTH'(INSTR_BYTES);

  // A push in the mispredict/flush cycle is accepted and then discarded by this clear.
  assign w_clear = !w_run | w_mis | bus.i_flush;

  pred_queue #(
    .DEPTH (DEPTH)
  ) u_pred_queue (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_state           <= RUN;
      r_mispredict      <= 1'b0;
      r_redirect_pc     <= '0;
      r_bpu_update      <= 1'b0;
      r_bpu_taken       <= 1'b0;
      r_bpu_pc_exec     <= '0;
      r_bpu_target_exec <= '0;
      r_bpu_way_write   <= '0;
      r_underflow       <= 1'b0;
    end else begin
      case (r_state)
        RUN:     if (w_mis || bus.i_flush) r_state <= FLUSH;
        FLUSH:   if (!bus.i_flush)         r_state <= RUN;
        default:                           r_state <= RUN;
      endcase
      r_mispredict      <= w_mis;
      r_redirect_pc     <= w_pop ? w_redirect        : '0;
      r_bpu_update      <= w_pop & bus.i_exec_is_branch;
      r_bpu_taken       <= w_pop & bus.i_exec_taken;
      r_bpu_pc_exec     <= w_pop ? bus.i_exec_pc     : '0;
      r_bpu_target_exec <= w_pop ? bus.i_exec_target : '0;
      r_bpu_way_write   <= w_pop ? w_head.way        : '0;
      r_underflow       <= w_underflow;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Counters advance on the same edge that raises the matching pulse.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_pop && bus.i_exec_is_branch && (r_branch_count != 32'hFFFF_FFFF))
        r_branch_count <= r_branch_count + 32'd1;
      if (w_mis && (r_mispredict_count != 32'hFFFF_FFFF))
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign bus.o_branch_count     = r_branch_count;
  assign bus.o_mispredict_count = r_mispredict_count;
`else
  assign bus.o_branch_count     = 32'd0;
  assign bus.o_mispredict_count = 32'd0;
`endif

  assign bus.o_pred_ready      = w_ready;
  assign bus.o_mispredict      = r_mispredict;
  assign bus.o_redirect_pc     = r_redirect_pc;
  assign bus.o_bpu_update      = r_bpu_update;
  assign bus.o_bpu_taken       = r_bpu_taken;
  assign bus.o_bpu_pc_exec     = r_bpu_pc_exec;
  assign bus.o_bpu_target_exec = r_bpu_target_exec;
  assign bus.o_bpu_way_write   = r_bpu_way_write;
  assign bus.o_underflow       = r_underflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random traffic vs a queue model.
module tb_branch_resolve_unit;

  localparam int AW    = 64;
  localparam int DEPTH = 4;

  typedef struct {
    bit          taken;
    logic [63:0] target;
    logic [1:0]  way;
  } ent_t;

  logic i_clk;
  logic i_arst;
  int   n_vec;
  int   n_err;

  ent_t        m_q[$];
  bit          m_flush;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  branch_resolve_unit_if #(.ADDR_WIDTH(AW)) bus ();

  branch_resolve_unit #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_val({pfx, "_ready"},    64'(bus.o_pred_ready), 64'd0);
    chk_val({pfx, "_mis"},      64'(bus.o_mispredict), 64'd0);
    chk_val({pfx, "_redir"},    bus.o_redirect_pc, 64'd0);
    chk_val({pfx, "_upd"},      64'(bus.o_bpu_update), 64'd0);
    chk_val({pfx, "_taken"},    64'(bus.o_bpu_taken), 64'd0);
    chk_val({pfx, "_pc"},       bus.o_bpu_pc_exec, 64'd0);
    chk_val({pfx, "_tgt"},      bus.o_bpu_target_exec, 64'd0);
    chk_val({pfx, "_way"},      64'(bus.o_bpu_way_write), 64'd0);
    chk_val({pfx, "_uf"},       64'(bus.o_underflow), 64'd0);
    chk_val({pfx, "_bcnt"},     64'(bus.o_branch_count), 64'd0);
    chk_val({pfx, "_mcnt"},     64'(bus.o_mispredict_count), 64'd0);
  endtask

  task automatic drive_idle();
    bus.i_pred_valid     = 1'b0;
    bus.i_pred_taken     = 1'b0;
    bus.i_pred_target    = '0;
    bus.i_pred_way       = '0;
    bus.i_exec_valid     = 1'b0;
    bus.i_exec_is_branch = 1'b0;
    bus.i_exec_taken     = 1'b0;
    bus.i_exec_pc        = '0;
    bus.i_exec_target    = '0;
    bus.i_flush          = 1'b0;
  endtask

  // One clock of stimulus; model predicts ready now and the registered outputs after the edge.
  task automatic step(input bit pv, input bit pt, input logic [63:0] ptg, input logic [1:0] pw,
                      input bit ev, input bit eb, input bit et,
                      input logic [63:0] epc, input logic [63:0] etg, input bit fl);
    bit          e_ready, e_push, e_pop, e_mis, e_uf;
    logic [63:0] e_redir, e_pc, e_tgt;
    logic [1:0]  e_way;
    bit          e_upd, e_taken;
    ent_t        h, n;

    bus.i_pred_valid     = pv;
    bus.i_pred_taken     = pt;
    bus.i_pred_target    = ptg;
    bus.i_pred_way       = pw;
    bus.i_exec_valid     = ev;
    bus.i_exec_is_branch = eb;
    bus.i_exec_taken     = et;
    bus.i_exec_pc        = epc;
    bus.i_exec_target    = etg;
    bus.i_flush          = fl;
    #1;

    e_ready = !m_flush && (m_q.size() < DEPTH);
    chk_val("pred_ready", 64'(bus.o_pred_ready), 64'(e_ready));

    e_push = pv && e_ready;
    e_pop  = !m_flush && ev && (m_q.size() > 0);
    e_uf   = !m_flush && ev && (m_q.size() == 0);
    e_mis  = 1'b0;
    e_redir = '0; e_pc = '0; e_tgt = '0; e_way = '0; e_upd = 1'b0; e_taken = 1'b0;
    if (e_pop) begin
      h = m_q.pop_front();
      if (eb) e_mis = (h.taken != et) || (et && h.taken && (h.target != etg));
      else    e_mis = h.taken;
      e_redir = (eb && et) ? etg : epc + 64'd4;
      e_pc    = epc;
      e_tgt   = etg;
      e_way   = h.way;
      e_upd   = eb;
      e_taken = et;
    end
    if (e_push) begin
      n.taken = pt; n.target = ptg; n.way = pw;
      m_q.push_back(n);
    end
    if (m_flush) begin
      m_q.delete();
      m_flush = fl;
    end else if (e_mis || fl) begin
      m_q.delete();
      m_flush = 1'b1;
    end
`ifdef BRANCH_STATS_EN
    if (e_upd && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
    if (e_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
`endif

    @(posedge i_clk);
    #1;
    chk_val("mispredict",  64'(bus.o_mispredict), 64'(e_mis));
    chk_val("redirect_pc", bus.o_redirect_pc, e_redir);
    chk_val("bpu_update",  64'(bus.o_bpu_update), 64'(e_upd));
    chk_val("bpu_taken",   64'(bus.o_bpu_taken), 64'(e_taken));
    chk_val("bpu_pc",      bus.o_bpu_pc_exec, e_pc);
    chk_val("bpu_target",  bus.o_bpu_target_exec, e_tgt);
    chk_val("bpu_way",     64'(bus.o_bpu_way_write), 64'(e_way));
    chk_val("underflow",   64'(bus.o_underflow), 64'(e_uf));
    chk_val("branch_cnt",  64'(bus.o_branch_count), 64'(m_bcnt));
    chk_val("mispred_cnt", 64'(bus.o_mispredict_count), 64'(m_mcnt));
  endtask

  task automatic idle();
    step(0, 0, 64'h0, 2'd0, 0, 0, 0, 64'h0, 64'h0, 0);
  endtask

  task automatic push(input bit pt, input logic [63:0] ptg, input logic [1:0] pw);
    step(1, pt, ptg, pw, 0, 0, 0, 64'h0, 64'h0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_flush = 1'b0; m_bcnt = '0; m_mcnt = '0;
    drive_idle();
    i_arst = 1'b0;
    #12;
    chk_all_zero("rst");
    @(negedge i_clk);
    i_arst = 1'b1;
    @(posedge i_clk);
    #1;

    // Wrong direction on a branch.
    push(0, 64'h0, 2'd1);
    step(0, 0, 64'h0, 2'd0, 1, 1, 1, 64'h10, 64'h100, 0);
    idle();

    // Correct taken prediction with matching target.
    push(1, 64'h200, 2'd2);
    step(0, 0, 64'h0, 2'd0, 1, 1, 1, 64'h20, 64'h200, 0);

    // Non-branch predicted taken.
    push(1, 64'h300, 2'd3);
    step(0, 0, 64'h0, 2'd0, 1, 0, 0, 64'h40, 64'h0, 0);
    idle();

    // Fill, overflow attempt, pop+push at full, drain in order.
    for (int i = 0; i < DEPTH; i++) push(0, 64'h1000 + 64'(i), 2'(i));
    push(0, 64'h2000, 2'd3);
    step(1, 0, 64'h3000, 2'd2, 1, 1, 0, 64'h80, 64'h0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 64'h0, 2'd0, 1, 1, 0, 64'h84 + 64'(4*i), 64'h0, 0);

    // Mispredict with three queued, then underflow after the flush.
    for (int i = 0; i < 3; i++) push(1, 64'h500, 2'(i));
    step(1, 0, 64'h600, 2'd1, 1, 1, 1, 64'h90, 64'h504, 0);
    idle();
    step(0, 0, 64'h0, 2'd0, 1, 1, 1, 64'h94, 64'h0, 0);

    // Pointer wrap near top of the address space, flush inside flush.
    push(0, 64'h0, 2'd0);
    step(0, 0, 64'h0, 2'd0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 0);
    step(0, 0, 64'h0, 2'd0, 0, 0, 0, 64'h0, 64'h0, 1);
    step(1, 0, 64'h0, 2'd0, 0, 0, 0, 64'h0, 64'h0, 1);
    idle();

    // Asynchronous reset with two entries queued and a pulse pending.
    for (int i = 0; i < 3; i++) push(0, 64'h700, 2'(i));
    step(0, 0, 64'h0, 2'd0, 1, 1, 0, 64'hA0, 64'h0, 0);
    drive_idle();
    i_arst = 1'b0;
    #1;
    chk_all_zero("midrst");
    m_q.delete(); m_flush = 1'b0; m_bcnt = '0; m_mcnt = '0;
    @(negedge i_clk);
    i_arst = 1'b1;
    @(posedge i_clk);
    #1;
    step(0, 0, 64'h0, 2'd0, 1, 1, 0, 64'hB0, 64'h0, 0);

    for (int k = 0; k < 600; k++) begin
      bit          pv, pt, ev, eb, et, fl;
      logic [63:0] ptg, etg, epc;
      pv  = ($urandom_range(0, 3) != 0);
      pt  = $urandom_range(0, 1);
      ptg = 64'h100 * 64'($urandom_range(1, 3));
      ev  = ($urandom_range(0, 2) == 0);
      eb  = ($urandom_range(0, 3) != 0);
      et  = $urandom_range(0, 1);
      etg = 64'h100 * 64'($urandom_range(1, 3));
      epc = {$urandom(), $urandom()} & ~64'h3;
      fl  = ($urandom_range(0, 49) == 0);
      step(pv, pt, ptg, 2'($urandom_range(0, 3)), ev, eb, et, epc, etg, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
